// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/halt controller: load-use stall, branch flush, syscall halt
// with Go-edge resume, and saturating performance counters.
module pipeline_ctrl (
  input  logic        clk,
  input  logic        clr,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_R1_used,
  input  logic        ID_R2_used,
  input  logic        EX_Memtoreg,
  input  logic        EX_Regwrite,
  input  logic [4:0]  EX_Write_Reg,
  input  logic        EX_Redirect,
  input  logic        EX_Syscall,
  input  logic        Halt_req,
  input  logic        Go,
  output logic        PC_Enable,
  output logic        IF_ID_Enable,
  output logic        ID_EX_Enable,
  output logic        EX_MEM_Enable,
  output logic        MEM_WB_Enable,
  output logic        IF_ID_clr,
  output logic        ID_EX_clr,
  output logic        Halted,
  output logic [31:0] Cycle_count,
  output logic [15:0] Stall_count,
  output logic [15:0] Flush_count
);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_HALT   = 2'd1;
  localparam logic [1:0] S_RESUME = 2'd2;

  logic [1:0] state;
  logic [1:0] next_state;
  logic       go_d;
  logic       lu;
  logic       active;
  logic       stall;
  logic       flush;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  assign lu = EX_Memtoreg & EX_Regwrite & (EX_Write_Reg != 5'd0) &
              ((ID_R1_used & (ID_rs == EX_Write_Reg)) |
               (ID_R2_used & (ID_rt == EX_Write_Reg)));

  assign active = (state != S_HALT);
  // Redirect wins over a load-use stall: the stalled ID instruction is flushed anyway.
  assign flush  = active & EX_Redirect;
  assign stall  = active & lu & ~EX_Redirect;

  always_comb begin
    next_state = state;
    case (state)
      S_RUN:    if (EX_Syscall & Halt_req) next_state = S_HALT;
      S_HALT:   if (Go & ~go_d) next_state = S_RESUME;
      S_RESUME: next_state = S_RUN;
      default:  next_state = S_RUN;
    endcase
  end

  always_comb begin
    PC_Enable     = active;
    IF_ID_Enable  = active;
    ID_EX_Enable  = active;
    EX_MEM_Enable = active;
    MEM_WB_Enable = active;
    IF_ID_clr     = 1'b0;
    ID_EX_clr     = 1'b0;
    Halted        = (state == S_HALT);
    if (flush) begin
      IF_ID_clr = 1'b1;
      ID_EX_clr = 1'b1;
    end else if (stall) begin
      PC_Enable    = 1'b0;
      IF_ID_Enable = 1'b0;
      ID_EX_clr    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_RUN;
      go_d  <= 1'b0;
    end else begin
      state <= next_state;
      go_d  <= Go;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      Cycle_count <= 32'd0;
      Stall_count <= 16'd0;
      Flush_count <= 16'd0;
    end else begin
      if (active) Cycle_count <= sat_inc32(Cycle_count);
      if (stall)  Stall_count <= sat_inc16(Stall_count);
      if (flush)  Flush_count <= sat_inc16(Flush_count);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table, halt/reset/saturation
// sequences, and randomized traffic against a behavioural model.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic [4:0]  ID_rs, ID_rt, EX_Write_Reg;
  logic        ID_R1_used, ID_R2_used, EX_Memtoreg, EX_Regwrite;
  logic        EX_Redirect, EX_Syscall, Halt_req, Go;
  logic        PC_Enable, IF_ID_Enable, ID_EX_Enable, EX_MEM_Enable, MEM_WB_Enable;
  logic        IF_ID_clr, ID_EX_clr, Halted;
  logic [31:0] Cycle_count;
  logic [15:0] Stall_count, Flush_count;

  int checks = 0;
  int errors = 0;

  // Model: mode 0 = running, 1 = halted, 2 = the single resume cycle.
  int          m_mode;
  bit          m_go_prev;
  longint      m_cyc, m_stall, m_flush;

  pipeline_ctrl dut (
    .clk(clk), .clr(clr),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_R1_used(ID_R1_used), .ID_R2_used(ID_R2_used),
    .EX_Memtoreg(EX_Memtoreg), .EX_Regwrite(EX_Regwrite), .EX_Write_Reg(EX_Write_Reg),
    .EX_Redirect(EX_Redirect), .EX_Syscall(EX_Syscall), .Halt_req(Halt_req), .Go(Go),
    .PC_Enable(PC_Enable), .IF_ID_Enable(IF_ID_Enable), .ID_EX_Enable(ID_EX_Enable),
    .EX_MEM_Enable(EX_MEM_Enable), .MEM_WB_Enable(MEM_WB_Enable),
    .IF_ID_clr(IF_ID_clr), .ID_EX_clr(ID_EX_clr), .Halted(Halted),
    .Cycle_count(Cycle_count), .Stall_count(Stall_count), .Flush_count(Flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt;
    logic       r1, r2, mtr, rw;
    logic [4:0] wr;
    logic       redir;
    logic [7:0] exp;
  } vec_t;

  // Output vector order: PC, IF_ID, ID_EX, EX_MEM, MEM_WB enables, IF_ID_clr, ID_EX_clr, Halted
  function automatic logic [7:0] out_vec();
    return {PC_Enable, IF_ID_Enable, ID_EX_Enable, EX_MEM_Enable, MEM_WB_Enable,
            IF_ID_clr, ID_EX_clr, Halted};
  endfunction

  function automatic bit model_lu();
    if (!(EX_Memtoreg && EX_Regwrite) || EX_Write_Reg == 0) return 0;
    return (ID_R1_used && ID_rs == EX_Write_Reg) || (ID_R2_used && ID_rt == EX_Write_Reg);
  endfunction

  function automatic logic [7:0] model_out();
    if (clr) return 8'hF8;
    if (m_mode == 1) return 8'h01;
    if (EX_Redirect) return 8'hFE;
    if (model_lu()) return 8'h3A;
    return 8'hF8;
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_go_prev = 0; m_cyc = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic check_now(input string tag);
    #1;
    chk({tag, ".outs"}, out_vec(), model_out());
    chk({tag, ".cycles"}, Cycle_count, m_cyc);
    chk({tag, ".stalls"}, Stall_count, m_stall);
    chk({tag, ".flushes"}, Flush_count, m_flush);
  endtask

  task automatic tick();
    @(posedge clk);
    if (clr) model_reset();
    else begin
      if (m_mode != 1) begin
        if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
        if (EX_Redirect) begin
          if (m_flush < 65535) m_flush++;
        end else if (model_lu()) begin
          if (m_stall < 65535) m_stall++;
        end
      end
      case (m_mode)
        0: if (EX_Syscall && Halt_req) m_mode = 1;
        1: if (Go && !m_go_prev) m_mode = 2;
        default: m_mode = 0;
      endcase
      m_go_prev = Go;
    end
    #1;
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic r1,
                        input logic r2, input logic mtr, input logic rw,
                        input logic [4:0] wr, input logic redir);
    ID_rs = rs; ID_rt = rt; ID_R1_used = r1; ID_R2_used = r2;
    EX_Memtoreg = mtr; EX_Regwrite = rw; EX_Write_Reg = wr; EX_Redirect = redir;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{5'd8,  5'd0, 1, 0, 1, 1, 5'd8,  0, 8'h3A};
    vecs[1] = '{5'd0,  5'd0, 1, 0, 1, 1, 5'd0,  0, 8'hF8};
    vecs[2] = '{5'd1,  5'd9, 0, 1, 1, 1, 5'd9,  0, 8'h3A};
    vecs[3] = '{5'd1,  5'd9, 0, 0, 1, 1, 5'd9,  0, 8'hF8};
    vecs[4] = '{5'd8,  5'd0, 1, 0, 0, 1, 5'd8,  0, 8'hF8};
    vecs[5] = '{5'd8,  5'd0, 1, 0, 1, 0, 5'd8,  0, 8'hF8};
    vecs[6] = '{5'd8,  5'd0, 1, 0, 1, 1, 5'd8,  1, 8'hFE};
    vecs[7] = '{5'd3,  5'd4, 1, 1, 0, 0, 5'd5,  1, 8'hFE};
    vecs[8] = '{5'd8,  5'd7, 1, 1, 1, 1, 5'd6,  0, 8'hF8};
    vecs[9] = '{5'd31, 5'd0, 1, 0, 1, 1, 5'd31, 0, 8'h3A};

    clr = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    EX_Syscall = 0; Halt_req = 0; Go = 0;
    model_reset();
    #2;
    chk("reset.outs", out_vec(), 8'hF8);
    chk("reset.cycles", Cycle_count, 0);
    tick();
    check_now("reset_hold");
    clr = 1'b0;
    check_now("after_reset");

    // Vector table in RUN
    foreach (vecs[i]) begin
      set_in(vecs[i].rs, vecs[i].rt, vecs[i].r1, vecs[i].r2,
             vecs[i].mtr, vecs[i].rw, vecs[i].wr, vecs[i].redir);
      #1;
      chk($sformatf("vec%0d.table", i), out_vec(), vecs[i].exp);
      check_now($sformatf("vec%0d", i));
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    check_now("vec_end");

    // Halt, frozen cycle counter, Go held high, single resume cycle
    EX_Syscall = 1; Halt_req = 1;
    check_now("halt_entry");
    tick();
    chk("halt.halted", Halted, 1);
    check_now("halt1");
    tick(); check_now("halt2");
    tick(); check_now("halt3");
    Go = 1;
    check_now("halt_go");
    tick();
    chk("resume.halted", Halted, 0);
    check_now("resume");
    tick();
    EX_Syscall = 0;
    for (int k = 0; k < 3; k++) begin
      chk("run_after_resume.halted", Halted, 0);
      check_now("go_held");
      tick();
    end
    Go = 0; Halt_req = 0;
    check_now("go_low");

    // Async reset while halted, between edges
    EX_Syscall = 1; Halt_req = 1;
    tick();
    EX_Syscall = 0;
    check_now("halt_before_reset");
    @(negedge clk);
    clr = 1'b1;
    #1;
    chk("async.halted", Halted, 0);
    chk("async.cycles", Cycle_count, 0);
    chk("async.flushes", Flush_count, 0);
    model_reset();
    tick();
    clr = 1'b0;
    Halt_req = 0;
    check_now("after_async");

    // Stall counter saturation
    set_in(5'd8, 5'd0, 1, 0, 1, 1, 5'd8, 0);
    for (int k = 0; k < 65535; k++) tick();
    chk("sat.stall_full", Stall_count, 16'hFFFF);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("sat.stall_hold", Stall_count, 16'hFFFF);
    end
    check_now("sat_end");

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0));
      EX_Syscall = 1'($urandom_range(0, 15) == 0);
      Halt_req   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) Go = ~Go;
      check_now("rand");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
